mux_rr_arbiter: RTL

Round-robin arbiter and sequencer for a shared N-input data multiplexer. It accepts packets from N valid/ready requesters and selects one requester at a time onto a single registered output channel. A grant is held for a whole packet, delimited by `req_last`. The block sits in front of any shared downstream resource that the mux datapath feeds, and it owns the mux select.

---
 rtl/mux_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 28 ++
 rtl/mux_rr_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package mux_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Increment with wrap back to zero at n (i.e. (v + 1) mod n for v < n).
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Walk ptr, ptr+1, ... N-1, 0, ... ptr-1 and latch the first hit.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = 0; k < N; k++) begin
      cand = SEL_W'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin packet arbiter driving a registered N:1 data mux.
//
//   state  | meaning
//   ARB    | no packet in flight; winner picked by rotating priority from ptr
//   LOCKED | packet from owner in flight; only owner may transfer until its last beat
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [N-1:0]     req_last,
  input  logic [N*W-1:0]   req_data,
  output logic [N-1:0]     req_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_sel,
  output logic             out_last,
  input  logic             out_ready
);

  arb_state_t       state, state_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt;
  logic [SEL_W-1:0] owner, owner_nxt;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic             slot_free;
  logic             xfer;
  logic [SEL_W-1:0] sel;
  logic [W-1:0]     sel_data;
  logic             sel_last;

  rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign slot_free = !out_valid || out_ready;
  assign sel       = (state == LOCKED) ? owner : pick_idx;
  assign xfer      = |(req_valid & req_ready);
  assign sel_last  = req_last[sel];

  // Grant decode: one-hot to the current winner/owner when the slot can take a beat.
  always_comb begin
    req_ready = '0;
    if (!rst && slot_free) begin
      if (state == LOCKED) begin
        req_ready[owner] = 1'b1;
      end else if (pick_any) begin
        req_ready[pick_idx] = 1'b1;
      end
    end
  end

  // Data mux for the selected requester.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SEL_W'(i)) sel_data = req_data[i*W +: W];
    end
  end

  // Next-state, pointer and owner update on packet boundaries.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    if (xfer) begin
      if (sel_last) begin
        state_nxt = ARB;
        ptr_nxt   = SEL_W'(wrap_inc(int'(sel), N));
      end else begin
        state_nxt = LOCKED;
        owner_nxt = sel;
      end
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
    end
  end

  // Output slot: load on transfer, otherwise drain when downstream accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      out_last  <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= sel;
      out_last  <= sel_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
